// File: rtl/mem_stage_access.sv
// MEM stage: data-memory req/ready access, upstream stall, MEM/WB register.
// Ports: EXE/MEM inputs (m*), dmem_* port, stall/pcsrc, W* outputs, errors.
module mem_stage_access #(
  parameter int DW      = 32,
  parameter int RW      = 5,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          mwreg,
  input  logic          mm2reg,
  input  logic          mwmem,
  input  logic [DW-1:0] maluout,
  input  logic [DW-1:0] mdata_b,
  input  logic [RW-1:0] mrdrt,
  input  logic          mbranch,
  input  logic          mzero,
  output logic          dmem_req,
  output logic          dmem_we,
  output logic [DW-1:0] dmem_addr,
  output logic [DW-1:0] dmem_wdata,
  input  logic          dmem_ready,
  input  logic [DW-1:0] dmem_rdata,
  output logic          stall,
  output logic          pcsrc,
  output logic          wwreg,
  output logic          wm2reg,
  output logic [DW-1:0] wmo,
  output logic [DW-1:0] walu,
  output logic [RW-1:0] wrn,
  output logic          align_err,
  output logic          bus_err
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          req_q, req_d;
  logic          we_q, we_d;
  logic [DW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rbuf_q, rbuf_d;
  logic          align_q, align_d;
  logic          bus_q, bus_d;
  logic          wwreg_q, wwreg_d;
  logic          wm2reg_q, wm2reg_d;
  logic [DW-1:0] wmo_q, wmo_d;
  logic [DW-1:0] walu_q, walu_d;
  logic [RW-1:0] wrn_q, wrn_d;

  logic acc;
  logic mis;
  logic stall_c;

  assign acc = mm2reg | mwmem;
  assign mis = acc & (maluout[1:0] != 2'b00);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rbuf_d  = rbuf_q;
    align_d = align_q;
    bus_d   = bus_q;
    stall_c = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (mis) begin
          align_d = 1'b1;
        end else if (acc) begin
          state_d = ACCESS;
          req_d   = 1'b1;
          we_d    = mwmem;
          addr_d  = maluout;
          wdata_d = mdata_b;
          stall_c = 1'b1;
        end
      end
      ACCESS: begin
        stall_c = 1'b1;
        cnt_d   = cnt_q + CW'(1);
        if (dmem_ready) begin
          rbuf_d  = we_q ? '0 : dmem_rdata;
          req_d   = 1'b0;
          state_d = DONE;
        end else if (cnt_q == LAST) begin
          bus_d   = 1'b1;
          rbuf_d  = '0;
          req_d   = 1'b0;
          state_d = DONE;
        end
      end
      DONE: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        req_d   = 1'b0;
      end
    endcase
  end

  // A stalled cycle inserts a bubble; only the enables are cleared.
  always_comb begin
    wwreg_d  = wwreg_q;
    wm2reg_d = wm2reg_q;
    wmo_d    = wmo_q;
    walu_d   = walu_q;
    wrn_d    = wrn_q;
    if (stall_c) begin
      wwreg_d  = 1'b0;
      wm2reg_d = 1'b0;
    end else begin
      wwreg_d  = mwreg & ~mis;
      wm2reg_d = mm2reg;
      walu_d   = maluout;
      wrn_d    = mrdrt;
      wmo_d    = (state_q == DONE) ? rbuf_q : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rbuf_q   <= '0;
      align_q  <= 1'b0;
      bus_q    <= 1'b0;
      wwreg_q  <= 1'b0;
      wm2reg_q <= 1'b0;
      wmo_q    <= '0;
      walu_q   <= '0;
      wrn_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      req_q    <= req_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rbuf_q   <= rbuf_d;
      align_q  <= align_d;
      bus_q    <= bus_d;
      wwreg_q  <= wwreg_d;
      wm2reg_q <= wm2reg_d;
      wmo_q    <= wmo_d;
      walu_q   <= walu_d;
      wrn_q    <= wrn_d;
    end
  end

  // No stall is raised while reset is held, even if a load waits upstream.
  assign stall      = stall_c & ~rst;
  assign pcsrc      = mbranch & mzero;
  assign dmem_req   = req_q;
  assign dmem_we    = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_wdata = wdata_q;
  assign wwreg      = wwreg_q;
  assign wm2reg     = wm2reg_q;
  assign wmo        = wmo_q;
  assign walu       = walu_q;
  assign wrn        = wrn_q;
  assign align_err  = align_q;
  assign bus_err    = bus_q;

endmodule

// File: tb/tb_mem_stage_access.sv
// Directed bench for mem_stage_access: ALU pass, load, store, misalign,
// timeout, reset mid-access and branch resolution.
module tb_mem_stage_access;

  localparam int DW = 32;
  localparam int RW = 5;
  localparam int TO = 255;

  logic          clk;
  logic          rst;
  logic          mwreg, mm2reg, mwmem;
  logic [DW-1:0] maluout, mdata_b;
  logic [RW-1:0] mrdrt;
  logic          mbranch, mzero;
  logic          dmem_req, dmem_we;
  logic [DW-1:0] dmem_addr, dmem_wdata;
  logic          dmem_ready;
  logic [DW-1:0] dmem_rdata;
  logic          stall, pcsrc;
  logic          wwreg, wm2reg;
  logic [DW-1:0] wmo, walu;
  logic [RW-1:0] wrn;
  logic          align_err, bus_err;

  int checks;
  int errors;

  mem_stage_access #(.DW(DW), .RW(RW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .mwreg(mwreg), .mm2reg(mm2reg), .mwmem(mwmem),
    .maluout(maluout), .mdata_b(mdata_b), .mrdrt(mrdrt),
    .mbranch(mbranch), .mzero(mzero),
    .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .stall(stall), .pcsrc(pcsrc),
    .wwreg(wwreg), .wm2reg(wm2reg),
    .wmo(wmo), .walu(walu), .wrn(wrn),
    .align_err(align_err), .bus_err(bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in;
    mwreg = 0; mm2reg = 0; mwmem = 0;
    maluout = '0; mdata_b = '0; mrdrt = '0;
    mbranch = 0; mzero = 0;
    dmem_ready = 0; dmem_rdata = '0;
  endtask

  task automatic test_reset;
    rst = 1;
    clr_in();
    tick();
    tick();
    checks++;
    if (dmem_req !== 1'b0 || dmem_we !== 1'b0) begin
      errors++;
      $display("FAIL rst_req got req=%0b we=%0b exp 0", dmem_req, dmem_we);
    end
    checks++;
    if (dmem_addr !== '0 || dmem_wdata !== '0) begin
      errors++;
      $display("FAIL rst_bus got addr=%h wdata=%h exp 0", dmem_addr, dmem_wdata);
    end
    checks++;
    if (wwreg !== 0 || wm2reg !== 0 || wmo !== '0 || walu !== '0 || wrn !== '0) begin
      errors++;
      $display("FAIL rst_wb got wwreg=%0b wm2reg=%0b wmo=%h walu=%h wrn=%0d exp 0",
               wwreg, wm2reg, wmo, walu, wrn);
    end
    checks++;
    if (align_err !== 0 || bus_err !== 0 || stall !== 0) begin
      errors++;
      $display("FAIL rst_flags got align=%0b bus=%0b stall=%0b exp 0",
               align_err, bus_err, stall);
    end
    rst = 0;
  endtask

  task automatic test_alu;
    mwreg = 1; maluout = 32'h10; mrdrt = 5'd3;
    #1;
    checks++;
    if (stall !== 1'b0) begin
      errors++;
      $display("FAIL alu_stall got %0b exp 0", stall);
    end
    tick();
    clr_in();
    checks++;
    if (wwreg !== 1'b1 || walu !== 32'h10 || wrn !== 5'd3 || wm2reg !== 1'b0) begin
      errors++;
      $display("FAIL alu_wb got wwreg=%0b walu=%h wrn=%0d wm2reg=%0b exp 1 10 3 0",
               wwreg, walu, wrn, wm2reg);
    end
    checks++;
    if (dmem_req !== 1'b0) begin
      errors++;
      $display("FAIL alu_req got %0b exp 0", dmem_req);
    end
  endtask

  task automatic test_load;
    mwreg = 1; mm2reg = 1; maluout = 32'h40; mrdrt = 5'd5;
    #1;
    checks++;
    if (stall !== 1'b1 || dmem_req !== 1'b0) begin
      errors++;
      $display("FAIL ld_c0 got stall=%0b req=%0b exp 1 0", stall, dmem_req);
    end
    tick();
    dmem_ready = 1; dmem_rdata = 32'hCAFEF00D;
    #1;
    checks++;
    if (dmem_req !== 1 || dmem_we !== 0 || dmem_addr !== 32'h40 || stall !== 1) begin
      errors++;
      $display("FAIL ld_acc got req=%0b we=%0b addr=%h stall=%0b exp 1 0 40 1",
               dmem_req, dmem_we, dmem_addr, stall);
    end
    checks++;
    if (wwreg !== 1'b0) begin
      errors++;
      $display("FAIL ld_bubble got wwreg=%0b exp 0", wwreg);
    end
    tick();
    dmem_ready = 0; dmem_rdata = '0;
    #1;
    checks++;
    if (dmem_req !== 1'b0 || stall !== 1'b0 || wwreg !== 1'b0) begin
      errors++;
      $display("FAIL ld_done got req=%0b stall=%0b wwreg=%0b exp 0 0 0",
               dmem_req, stall, wwreg);
    end
    tick();
    clr_in();
    mwreg = 1; maluout = 32'h99; mrdrt = 5'd2;
    checks++;
    if (wwreg !== 1 || wm2reg !== 1 || wmo !== 32'hCAFEF00D || wrn !== 5'd5) begin
      errors++;
      $display("FAIL ld_wb got wwreg=%0b wm2reg=%0b wmo=%h wrn=%0d exp 1 1 cafef00d 5",
               wwreg, wm2reg, wmo, wrn);
    end
    #1;
    checks++;
    if (stall !== 1'b0) begin
      errors++;
      $display("FAIL b2b_stall got %0b exp 0", stall);
    end
    tick();
    clr_in();
    checks++;
    if (wwreg !== 1 || walu !== 32'h99 || wm2reg !== 0 || wmo !== '0 || wrn !== 5'd2) begin
      errors++;
      $display("FAIL b2b_wb got wwreg=%0b walu=%h wm2reg=%0b wmo=%h wrn=%0d exp 1 99 0 0 2",
               wwreg, walu, wm2reg, wmo, wrn);
    end
  endtask

  task automatic test_store;
    int stall_n;
    int req_n;
    bit stable;
    bit ended;
    stall_n = 0; req_n = 0; stable = 1; ended = 0;
    mwmem = 1; maluout = 32'h44; mdata_b = 32'h12345678; mrdrt = 5'd6;
    for (int c = 0; c < 20; c++) begin
      if (dmem_req) begin
        req_n++;
        if (dmem_we !== 1 || dmem_addr !== 32'h44 || dmem_wdata !== 32'h12345678)
          stable = 0;
      end
      dmem_ready = (req_n == 3);
      #1;
      if (stall) begin
        stall_n++;
      end else begin
        ended = 1;
        break;
      end
      tick();
    end
    dmem_ready = 0;
    checks++;
    if (!ended) begin
      errors++;
      $display("FAIL st_bound got stall still high exp release");
    end
    checks++;
    if (stall_n != 4 || req_n != 3) begin
      errors++;
      $display("FAIL st_len got stall=%0d req=%0d exp 4 3", stall_n, req_n);
    end
    checks++;
    if (!stable) begin
      errors++;
      $display("FAIL st_hold got unstable we/addr/wdata exp 1 44 12345678");
    end
    tick();
    clr_in();
    checks++;
    if (wwreg !== 0 || wmo !== '0 || dmem_req !== 0) begin
      errors++;
      $display("FAIL st_wb got wwreg=%0b wmo=%h req=%0b exp 0 0 0", wwreg, wmo, dmem_req);
    end
  endtask

  task automatic test_misaligned;
    mwreg = 1; mm2reg = 1; maluout = 32'h42; mrdrt = 5'd7;
    #1;
    checks++;
    if (stall !== 1'b0) begin
      errors++;
      $display("FAIL mis_stall got %0b exp 0", stall);
    end
    tick();
    clr_in();
    checks++;
    if (align_err !== 1 || wwreg !== 0 || dmem_req !== 0 || bus_err !== 0) begin
      errors++;
      $display("FAIL mis_ld got align=%0b wwreg=%0b req=%0b bus=%0b exp 1 0 0 0",
               align_err, wwreg, dmem_req, bus_err);
    end
    mwmem = 1; maluout = 32'h45; mdata_b = 32'hFFFF;
    tick();
    clr_in();
    checks++;
    if (dmem_req !== 0 || wwreg !== 0 || align_err !== 1) begin
      errors++;
      $display("FAIL mis_st got req=%0b wwreg=%0b align=%0b exp 0 0 1",
               dmem_req, wwreg, align_err);
    end
  endtask

  task automatic test_timeout;
    int stall_n;
    bit ended;
    stall_n = 0; ended = 0;
    mwreg = 1; mm2reg = 1; maluout = 32'h80; mrdrt = 5'd9;
    dmem_rdata = 32'hDEADBEEF;
    for (int c = 0; c < 400; c++) begin
      #1;
      if (stall) begin
        stall_n++;
      end else begin
        ended = 1;
        break;
      end
      tick();
    end
    checks++;
    if (!ended || stall_n != TO + 1) begin
      errors++;
      $display("FAIL to_len got stall=%0d ended=%0b exp %0d 1", stall_n, ended, TO + 1);
    end
    checks++;
    if (bus_err !== 1'b1 || dmem_req !== 1'b0) begin
      errors++;
      $display("FAIL to_err got bus=%0b req=%0b exp 1 0", bus_err, dmem_req);
    end
    dmem_ready = 1;
    tick();
    clr_in();
    checks++;
    if (wmo !== '0 || wwreg !== 1 || wrn !== 5'd9) begin
      errors++;
      $display("FAIL to_wb got wmo=%h wwreg=%0b wrn=%0d exp 0 1 9", wmo, wwreg, wrn);
    end
  endtask

  task automatic test_reset_mid;
    mwreg = 1; mm2reg = 1; maluout = 32'h48; mrdrt = 5'd4;
    tick();
    tick();
    #1;
    checks++;
    if (dmem_req !== 1 || stall !== 1) begin
      errors++;
      $display("FAIL rm_acc got req=%0b stall=%0b exp 1 1", dmem_req, stall);
    end
    rst = 1;
    tick();
    checks++;
    if (dmem_req !== 0 || stall !== 0 || dmem_addr !== '0) begin
      errors++;
      $display("FAIL rm_drop got req=%0b stall=%0b addr=%h exp 0 0 0",
               dmem_req, stall, dmem_addr);
    end
    checks++;
    if (align_err !== 0 || bus_err !== 0 || walu !== '0 || wrn !== '0) begin
      errors++;
      $display("FAIL rm_clr got align=%0b bus=%0b walu=%h wrn=%0d exp 0",
               align_err, bus_err, walu, wrn);
    end
    clr_in();
    rst = 0;
    tick();
    checks++;
    if (dmem_req !== 0 || wwreg !== 0) begin
      errors++;
      $display("FAIL rm_idle got req=%0b wwreg=%0b exp 0 0", dmem_req, wwreg);
    end
  endtask

  task automatic test_branch;
    mbranch = 1; mzero = 1;
    #1;
    checks++;
    if (pcsrc !== 1'b1) begin
      errors++;
      $display("FAIL br_taken got %0b exp 1", pcsrc);
    end
    mzero = 0;
    #1;
    checks++;
    if (pcsrc !== 1'b0) begin
      errors++;
      $display("FAIL br_not got %0b exp 0", pcsrc);
    end
    clr_in();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_alu();
    test_load();
    test_store();
    test_misaligned();
    test_timeout();
    test_reset_mid();
    test_branch();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
